// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter
// Shares one single-ported RAM (1-cycle read latency, per-bit write mask)
// between the LC-3 instruction-fetch port and the load/store data port.
// At most one access is issued per cycle. The returned word is routed to the
// port that issued it, and one response is buffered if that port stalls.
//
// Handshakes: a request transfers when *_req_valid && *_req_ready in the same
// cycle. A response transfers when *_resp_valid && *_resp_ready. A valid
// request or response holds its payload until it is taken.
//
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   f_req_valid/ready/addr            fetch read request
//   f_resp_valid/ready/rdata          fetch response
//   d_req_valid/ready/addr/wdata/
//     wmask/wen                       data load/store request
//   d_resp_valid/ready/rdata          data response (rdata = 0 for stores)
//   ram_rIdx/ram_rdata                RAM read index / data (next cycle)
//   ram_wIdx/wdata/wmask/wen          RAM write port
//   o_dbg_state                       FSM state (0 IDLE, 1 PEND, 2 HOLD)
module lc3_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DATA_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_resp_valid,
  input  logic              f_resp_ready,
  output logic [DATA_W-1:0] f_resp_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [DATA_W-1:0] d_req_wmask,
  input  logic              d_req_wen,
  output logic              d_resp_valid,
  input  logic              d_resp_ready,
  output logic [DATA_W-1:0] d_resp_rdata,
  output logic [ADDR_W-1:0] ram_rIdx,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_wIdx,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] ram_wmask,
  output logic              ram_wen,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t              r_state;
  state_t              w_next;
  logic                r_owner;
  logic                r_is_store;
  logic                r_last_grant;
  logic [DATA_W-1:0]   r_hold;
  logic [ADDR_W-1:0]   r_ridx;

  logic                w_owner_ready;
  logic                w_can_issue;
  logic                w_gnt_f;
  logic                w_gnt_d;
  logic                w_issue;
  logic                w_issue_store;
  logic [ADDR_W-1:0]   w_gnt_addr;
  logic                w_resp_valid;
  logic [DATA_W-1:0]   w_resp_data;

  assign o_dbg_state = r_state;

  // A new access may only go out when the slot it would overwrite is free:
  // either nothing is outstanding, or the current response completes now.
  assign w_owner_ready = (r_owner == OWN_D) ? d_resp_ready : f_resp_ready;
  assign w_can_issue   = (r_state == S_IDLE) ? 1'b1 : w_owner_ready;

  always_comb begin
    w_gnt_f = 1'b0;
    w_gnt_d = 1'b0;
    if (!reset && w_can_issue) begin
      if (f_req_valid && d_req_valid) begin
        // Round-robin: serve the port that did not win last time.
        if ((DATA_FIRST != 0) || (r_last_grant == OWN_F)) begin
          w_gnt_d = 1'b1;
        end else begin
          w_gnt_f = 1'b1;
        end
      end else begin
        w_gnt_f = f_req_valid;
        w_gnt_d = d_req_valid;
      end
    end
  end

  assign w_issue       = w_gnt_f | w_gnt_d;
  assign w_issue_store = w_gnt_d & d_req_wen;
  assign w_gnt_addr    = w_gnt_d ? d_req_addr : f_req_addr;

  assign f_req_ready = w_gnt_f;
  assign d_req_ready = w_gnt_d;

  // RAM side: the index tracks the last issued address when idle so the
  // RAM read port is not toggled needlessly.
  assign ram_rIdx  = reset ? '0 : (w_issue ? w_gnt_addr : r_ridx);
  assign ram_wIdx  = ram_rIdx;
  assign ram_wen   = w_issue_store;
  assign ram_wdata = w_issue_store ? d_req_wdata : '0;
  assign ram_wmask = w_issue_store ? d_req_wmask : '0;

  // Response side: in PEND the RAM word is forwarded combinationally; in
  // HOLD the captured copy is used. Stores always return zero.
  assign w_resp_valid = !reset && (r_state != S_IDLE);
  always_comb begin
    w_resp_data = '0;
    if (r_state == S_HOLD) begin
      w_resp_data = r_hold;
    end else if (!r_is_store) begin
      w_resp_data = ram_rdata;
    end
  end

  assign f_resp_valid = w_resp_valid && (r_owner == OWN_F);
  assign d_resp_valid = w_resp_valid && (r_owner == OWN_D);
  assign f_resp_rdata = f_resp_valid ? w_resp_data : '0;
  assign d_resp_rdata = d_resp_valid ? w_resp_data : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue) w_next = S_PEND;
      end
      S_PEND: begin
        if (w_owner_ready) begin
          w_next = w_issue ? S_PEND : S_IDLE;
        end else begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_owner_ready) begin
          w_next = w_issue ? S_PEND : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_F;
      r_is_store   <= 1'b0;
      r_last_grant <= OWN_F;
      r_hold       <= '0;
      r_ridx       <= '0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_owner      <= w_gnt_d;
        r_is_store   <= w_issue_store;
        r_last_grant <= w_gnt_d;
        r_ridx       <= w_gnt_addr;
      end
      // RAM data is only valid for one cycle; keep it if the owner stalls.
      if ((r_state == S_PEND) && !w_owner_ready) begin
        r_hold <= r_is_store ? '0 : ram_rdata;
      end
    end
  end

endmodule
